// File: rtl/mac_vlg_tx_framer.sv
// GMII-style transmit framer: preamble, SFD, data, optional zero pad, CRC-32 FCS, inter-frame gap.
// Define MAC_VLG_TX_FRAMER_PAD_EN to pad short frames with 0x00 up to MIN_LEN bytes before the FCS.
module mac_vlg_tx_framer #(
   parameter int unsigned PREAMBLE_LEN = 7,
   parameter int unsigned IFG_BYTES    = 12,
   parameter int unsigned MIN_LEN      = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_dat,
   input  logic        in_val,
   input  logic        in_last,
   output logic        in_rdy,
   output logic [7:0]  phy_dat,
   output logic        phy_val,
   output logic        phy_err,
   output logic        busy,
   output logic        done,
   output logic [15:0] frm_cnt
);

   typedef enum logic [2:0] {
      IDLE, PRE, SFD, DATA,
`ifdef MAC_VLG_TX_FRAMER_PAD_EN
      PAD,
`endif
      FCS, IFG
   } state_t;

   state_t      state, state_n;
   logic [15:0] tcnt, tcnt_n;
   logic [10:0] cnt, cnt_n, cnt_inc;
   logic [31:0] crc, crc_n, fcs;
   logic [7:0]  phy_dat_n;
   logic        phy_val_n, phy_err_n, done_n;
   logic [15:0] frm_cnt_n;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h000000, d};
      for (int unsigned i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // State names the phase deciding the next registered phy byte; the wire lags it by one cycle.
   assign in_rdy = (state == SFD) || (state == DATA);
   assign busy   = (state != IDLE);

   always_comb begin
      state_n   = state;
      tcnt_n    = tcnt;
      cnt_n     = cnt;
      crc_n     = crc;
      phy_dat_n = 8'h00;
      phy_val_n = 1'b0;
      phy_err_n = 1'b0;
      done_n    = 1'b0;
      frm_cnt_n = frm_cnt;
      fcs       = ~crc;
      cnt_inc   = (cnt == '1) ? cnt : cnt + 11'd1;
      case (state)
         IDLE: begin
            cnt_n  = '0;
            crc_n  = '1;
            tcnt_n = '0;
            if (in_val) begin
               state_n   = PRE;
               phy_dat_n = 8'h55;
               phy_val_n = 1'b1;
            end
         end
         PRE: begin
            phy_val_n = 1'b1;
            tcnt_n    = tcnt + 16'd1;
            if (tcnt == 16'(PREAMBLE_LEN - 1)) begin
               phy_dat_n = 8'hD5;
               tcnt_n    = '0;
               state_n   = SFD;
            end else begin
               phy_dat_n = 8'h55;
            end
         end
         SFD, DATA: begin
            phy_val_n = 1'b1;
            if (in_val) begin
               phy_dat_n = in_dat;
               crc_n     = crc_byte(crc, in_dat);
               cnt_n     = cnt_inc;
               state_n   = DATA;
               if (in_last) begin
                  state_n = FCS;
`ifdef MAC_VLG_TX_FRAMER_PAD_EN
                  if (32'(cnt_inc) < MIN_LEN) state_n = PAD;
`endif
               end
            end else begin
               phy_err_n = 1'b1;
               tcnt_n    = '0;
               state_n   = IFG;
            end
         end
`ifdef MAC_VLG_TX_FRAMER_PAD_EN
         PAD: begin
            phy_val_n = 1'b1;
            crc_n     = crc_byte(crc, 8'h00);
            cnt_n     = cnt_inc;
            if (32'(cnt_inc) >= MIN_LEN) state_n = FCS;
         end
`endif
         FCS: begin
            phy_val_n = 1'b1;
            phy_dat_n = fcs[{tcnt[1:0], 3'b000} +: 8];
            tcnt_n    = tcnt + 16'd1;
            if (tcnt[1:0] == 2'd3) begin
               done_n    = 1'b1;
               frm_cnt_n = frm_cnt + 16'd1;
               tcnt_n    = '0;
               state_n   = IFG;
            end
         end
         IFG: begin
            tcnt_n = tcnt + 16'd1;
            if (tcnt == 16'(IFG_BYTES - 1)) begin
               tcnt_n  = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         tcnt    <= '0;
         cnt     <= '0;
         crc     <= '1;
         phy_dat <= 8'h00;
         phy_val <= 1'b0;
         phy_err <= 1'b0;
         done    <= 1'b0;
         frm_cnt <= '0;
      end else begin
         state   <= state_n;
         tcnt    <= tcnt_n;
         cnt     <= cnt_n;
         crc     <= crc_n;
         phy_dat <= phy_dat_n;
         phy_val <= phy_val_n;
         phy_err <= phy_err_n;
         done    <= done_n;
         frm_cnt <= frm_cnt_n;
      end
   end

endmodule

// File: tb/tb_mac_vlg_tx_framer.sv
// Scoreboard bench for mac_vlg_tx_framer: driver pushes expected wire bytes, negedge monitor pops and compares.
module tb_mac_vlg_tx_framer;
   localparam int PRE_N = 7;
   localparam int IFG_N = 12;
   localparam int MINL  = 60;
   localparam int BIG   = 1000000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_dat = 8'h00;
   logic        in_val = 1'b0;
   logic        in_last = 1'b0;
   logic        in_rdy;
   logic [7:0]  phy_dat;
   logic        phy_val, phy_err, busy, done;
   logic [15:0] frm_cnt;

   mac_vlg_tx_framer #(.PREAMBLE_LEN(PRE_N), .IFG_BYTES(IFG_N), .MIN_LEN(MINL)) dut (
      .clk(clk), .rst(rst), .in_dat(in_dat), .in_val(in_val), .in_last(in_last),
      .in_rdy(in_rdy), .phy_dat(phy_dat), .phy_val(phy_val), .phy_err(phy_err),
      .busy(busy), .done(done), .frm_cnt(frm_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] dat;
      bit         chk_dat;
      bit         err;
      bit         dn;
      int         gmin;
      int         gmax;
      int         cnt;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          model_cnt = 0;
   bit          gap_free = 1'b1;
   bit          held = 1'b0;
   int          gap = 0;
   logic [31:0] crc_tab [256];
   logic [7:0]  frm[$];

   task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [7:0] d, input bit cd, input bit er, input bit dn, input int gmin, input int gmax);
      exp_t e;
      if (dn) model_cnt++;
      e.dat = d; e.chk_dat = cd; e.err = er; e.dn = dn;
      e.gmin = gmin; e.gmax = gmax; e.cnt = model_cnt;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] crc_model(input logic [7:0] b[$]);
      logic [31:0] c;
      c = '1;
      foreach (b[i]) c = (c >> 8) ^ crc_tab[c[7:0] ^ b[i]];
      return ~c;
   endfunction

   task automatic mk(input int len);
      frm.delete();
      for (int k = 0; k < len; k++) frm.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 200);
      check("idle_timeout", !busy, 32'(busy), 0);
   endtask

   // Monitor: every transmitted byte must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (phy_val) begin
         if (sb.size() == 0) begin
            check("unexpected_byte", 1'b0, 32'(phy_dat), 0);
         end else begin
            e = sb.pop_front();
            check("phy_dat", !e.chk_dat || phy_dat == e.dat, 32'(phy_dat), 32'(e.dat));
            check("phy_err", phy_err == e.err, 32'(phy_err), 32'(e.err));
            check("done", done == e.dn, 32'(done), 32'(e.dn));
            check("gap", gap >= e.gmin && gap <= e.gmax, 32'(gap), 32'(e.gmin));
            check("frm_cnt", frm_cnt == 16'(e.cnt), 32'(frm_cnt), 32'(e.cnt));
            check("busy_tx", busy == 1'b1, 32'(busy), 1);
         end
         gap = 0;
      end else begin
         check("idle_quiet", done == 1'b0 && phy_err == 1'b0, {30'd0, done, phy_err}, 0);
         gap++;
      end
   end

   task automatic send_frame(input logic [7:0] data[$], input int drop_at, input int rst_at,
                             input bit hold, input bit known);
      logic [7:0]  body[$];
      logic [31:0] fcs;
      int          i, lat, waits, gmin, gmax;
      bit          rdy, was_held;
      was_held = held;
      if (!held) begin
         wait_idle();
         @(posedge clk); #1;
      end
      if (gap_free) begin gmin = 0; gmax = BIG; end
      else if (held) begin gmin = IFG_N; gmax = IFG_N; end
      else begin gmin = IFG_N; gmax = BIG; end
      gap_free = 1'b0;
      for (int p = 0; p < PRE_N; p++) push(8'h55, 1, 0, 0, p == 0 ? gmin : 0, p == 0 ? gmax : 0);
      push(8'hD5, 1, 0, 0, 0, 0);
      in_val = 1'b1;
      i = 0; lat = 0; waits = 0;
      while (i < data.size()) begin
         in_dat  = data[i];
         in_last = (i == data.size() - 1);
         if (i == drop_at) in_val = 1'b0;
         if (i == rst_at) rst = 1'b0;
         @(negedge clk);
         rdy = in_rdy;
         if (i == 0 && !rdy) lat++;
         @(posedge clk); #1;
         if (i == rst_at) begin
            in_val = 1'b0; in_last = 1'b0;
            @(negedge clk);
            check("rst_phy_val", phy_val == 1'b0, 32'(phy_val), 0);
            check("rst_flush", sb.size() == 0, sb.size(), 0);
            sb.delete();
            model_cnt = 0;
            @(posedge clk); #1;
            @(negedge clk);
            check("rst_frm_cnt", frm_cnt == 16'h0000, 32'(frm_cnt), 0);
            check("rst_busy", busy == 1'b0 && in_rdy == 1'b0, {30'd0, busy, in_rdy}, 0);
            @(posedge clk); #1;
            rst = 1'b1;
            gap_free = 1'b1;
            held = 1'b0;
            return;
         end
         if (i == drop_at) begin
            check("underrun_rdy", rdy, 32'(rdy), 1);
            push(8'h00, 0, 1, 0, 0, 0);
            in_last = 1'b0;
            @(negedge clk);
            check("rdy_after_err", in_rdy == 1'b0, 32'(in_rdy), 0);
            held = 1'b0;
            return;
         end
         if (rdy) begin
            if (i == 0 && !was_held) check("rdy_latency", lat == PRE_N + 1, lat, PRE_N + 1);
            push(data[i], 1, 0, 0, 0, 0);
            body.push_back(data[i]);
            i++;
         end else begin
            waits++;
            if (waits > 100) begin
               check("rdy_timeout", 1'b0, waits, 0);
               in_val = 1'b0; in_last = 1'b0; held = 1'b0;
               return;
            end
         end
      end
`ifdef MAC_VLG_TX_FRAMER_PAD_EN
      while (body.size() < MINL) begin
         push(8'h00, 1, 0, 0, 0, 0);
         body.push_back(8'h00);
      end
      fcs = crc_model(body);
`else
      fcs = known ? 32'hCBF43926 : crc_model(body);
`endif
      for (int k = 0; k < 4; k++) push(fcs[8*k +: 8], 1, 0, k == 3, 0, 0);
      in_val  = hold;
      in_last = 1'b0;
      held    = hold;
   endtask

   initial begin
      int n;
      logic [31:0] v;
      for (int t = 0; t < 256; t++) begin
         v = 32'(t);
         for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
         crc_tab[t] = v;
      end
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_phy_val", phy_val == 1'b0, 32'(phy_val), 0);
      check("reset_phy_dat", phy_dat == 8'h00, 32'(phy_dat), 0);
      check("reset_phy_err", phy_err == 1'b0, 32'(phy_err), 0);
      check("reset_in_rdy", in_rdy == 1'b0, 32'(in_rdy), 0);
      check("reset_busy", busy == 1'b0, 32'(busy), 0);
      check("reset_done", done == 1'b0, 32'(done), 0);
      check("reset_frm_cnt", frm_cnt == 16'h0000, 32'(frm_cnt), 0);
      @(posedge clk); #1;
      rst = 1'b1;

      mk(60); send_frame(frm, -1, -1, 0, 0);
      frm.delete();
      for (int k = 0; k < 9; k++) frm.push_back(8'h31 + 8'(k));
      send_frame(frm, -1, -1, 0, 1);
      mk(14); send_frame(frm, -1, -1, 0, 0);
      mk(59); send_frame(frm, -1, -1, 0, 0);
      mk(61); send_frame(frm, -1, -1, 0, 0);
      mk(40); send_frame(frm, 20, -1, 0, 0);
      mk(30); send_frame(frm, -1, -1, 1, 0);
      mk(25); send_frame(frm, -1, -1, 0, 0);
      mk(1);  send_frame(frm, -1, -1, 1, 0);
      repeat (6) begin
         mk(int'($urandom_range(1, 100)));
         send_frame(frm, -1, -1, bit'($urandom_range(0, 1)), 0);
      end
      mk(50); send_frame(frm, -1, 30, 0, 0);
      mk(20); send_frame(frm, -1, -1, 0, 0);

      n = 0;
      while ((sb.size() != 0 || busy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size() == 0 && !busy, sb.size(), 0);
      check("final_frm_cnt", frm_cnt == 16'(model_cnt), 32'(frm_cnt), 32'(model_cnt));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog: actual=timeout required=completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mac_vlg_tx_framer.md
MAC_VLG_TX_FRAMER -- requirements
Module: mac_vlg_tx_framer

Interface
REQ-001 Parameter: PREAMBLE_LEN, default 7, number of 0x55 bytes sent before SFD.
REQ-002 Parameter: IFG_BYTES, default 12, idle cycles enforced after each frame.
REQ-003 Parameter: MIN_LEN, default 60, minimum frame length excluding FCS, used for padding.
REQ-004 Port: clk, input, 1, single clock; one clock for the whole block; every register is in this domain.
REQ-005 Port: rst, input, 1, reset; synchronous, active-low.
REQ-006 Port: in_dat, input, 8, frame byte from destination MAC through payload.
REQ-007 Port: in_val, input, 1, in_dat valid.
REQ-008 Port: in_last, input, 1, marks the final byte; qualified by in_val.
REQ-009 Port: in_rdy, output, 1, byte accepted when in_val & in_rdy.
REQ-010 Port: phy_dat, output, 8, GMII-style transmit byte.
REQ-011 Port: phy_val, output, 1, transmit enable.
REQ-012 Port: phy_err, output, 1, transmit error.
REQ-013 Port: busy, output, 1, high in every state other than IDLE.
REQ-014 Port: done, output, 1, one-cycle pulse on the cycle the last FCS byte is driven.
REQ-015 Port: frm_cnt, output, 16, count of completed frames; wraps from 0xFFFF to 0.

Function
REQ-016 FSM states SHALL be IDLE, PRE, SFD, DATA, PAD, FCS and IFG; phy_dat, phy_val and phy_err SHALL be registered.
REQ-017 Start: when in_val=1 in IDLE at cycle N, the block SHALL enter PRE; no byte is consumed at N.
REQ-018 Preamble and SFD: cycles N+1..N+PREAMBLE_LEN SHALL drive phy_val=1, phy_dat=0x55; cycle N+PREAMBLE_LEN+1 SHALL drive 0xD5.
REQ-019 Input handshake: in_rdy SHALL be high from cycle N+PREAMBLE_LEN+1 until in_last is accepted, and low at all other times.
REQ-020 Data latency: a byte accepted in cycle k SHALL appear on phy_dat in cycle k+1.
REQ-021 Underrun: if in_val=0 while in_rdy=1, the block SHALL drive phy_val=1, phy_err=1 for one cycle, discard the frame (no FCS, no done, frm_cnt unchanged), and enter IFG.
REQ-022 Byte counter: 11 bits, saturating at 2047; it counts data and pad bytes.
REQ-023 CRC: CRC-32 IEEE 802.3, reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, final XOR 0xFFFFFFFF, computed over data and pad bytes only.
REQ-024 FCS: the 4 FCS bytes SHALL immediately follow the last data or pad byte, least-significant byte first, with no gap.
REQ-025 IFG: phy_val=0 and in_rdy=0 for exactly IFG_BYTES cycles after the last FCS byte or error cycle; the block then returns to IDLE.
REQ-026 Back-to-back: in_val held high through IFG SHALL start the next frame on the first IDLE cycle.
REQ-027 phy_err SHALL be 0 except in the underrun case of REQ-021.
REQ-028 in_last on the same cycle as the final pad would be unneeded: if the byte count is already at least MIN_LEN, the block SHALL go straight to FCS.

Reset
REQ-029 While rst=0: state=IDLE, phy_dat=0x00, phy_val=0, phy_err=0, in_rdy=0, busy=0, done=0, frm_cnt=0, CRC=0xFFFFFFFF.
REQ-030 Reset asserted mid-frame SHALL force phy_val=0 on the next clock, skip IFG, and leave frm_cnt at 0.

Configuration
REQ-031 Macro MAC_VLG_TX_FRAMER_PAD_EN defined: after in_last, if the byte count is below MIN_LEN, the block SHALL send 0x00 pad bytes in PAD, included in the CRC, until the count equals MIN_LEN.
REQ-032 Macro not defined: the PAD state SHALL NOT be built, and the FCS SHALL follow in_last directly regardless of length.

Verification
REQ-033 Scenario: 60-byte frame, in_val continuous -> 72 consecutive phy_val cycles (7x0x55, 0xD5, 60 data, 4 FCS); done pulses on the 72nd; frm_cnt=1; then 12 idle cycles.
REQ-034 Scenario, PAD_EN undefined: 9-byte frame ASCII "123456789" -> FCS bytes 0x26 0x39 0xF4 0xCB.
REQ-035 Scenario, PAD_EN defined: 14-byte frame -> 46 bytes of 0x00 pad, 64 bytes after SFD, FCS matching a software model.
REQ-036 Scenario: in_val dropped after 20 accepted bytes -> one phy_err=1 cycle, then 12 idle cycles, no done, frm_cnt unchanged.
REQ-037 Scenario: two frames with in_val held high across the gap -> exactly 12 phy_val=0 cycles between frames; frm_cnt=2.
REQ-038 Scenario: rst=0 asserted in the 30th data cycle -> phy_val=0 on the next cycle; a new frame started after rst=1 is correct and frm_cnt=1.
